// File: rtl/fft_out_serializer_if.sv
// Handshake and data bundle between the FFT output lanes, the serializer
// and the downstream consumer of the natural-order sample stream.
interface fft_out_serializer_if #(
    parameter int NBITS_out = 10,
    parameter int N         = 128
);
    logic                    in_start;
    logic [2*NBITS_out-1:0]  fftOut0_up;
    logic [2*NBITS_out-1:0]  fftOut0_down;
    logic [2*NBITS_out-1:0]  fftOut1_up;
    logic [2*NBITS_out-1:0]  fftOut1_down;
    logic [2*NBITS_out-1:0]  dout;
    logic [$clog2(N)-1:0]    dout_index;
    logic                    dout_valid;
    logic                    dout_ready;
    logic                    dout_last;
    logic                    busy;
    logic                    overrun;
    logic                    overrun_clr;

    // The serializer sees the FFT lanes and the ready/clear controls as inputs
    modport slave (
        input  in_start, fftOut0_up, fftOut0_down, fftOut1_up, fftOut1_down,
        input  dout_ready, overrun_clr,
        output dout, dout_index, dout_valid, dout_last, busy, overrun
    );

    // The environment drives the lanes and consumes the serial stream
    modport master (
        output in_start, fftOut0_up, fftOut0_down, fftOut1_up, fftOut1_down,
        output dout_ready, overrun_clr,
        input  dout, dout_index, dout_valid, dout_last, busy, overrun
    );
endinterface

// File: rtl/fft_out_serializer.sv
// Captures one FFT frame delivered as groups of 4 lanes per clock into four
// storage banks, then drains it as a single natural-order valid/ready stream.
// Frames that arrive while a frame is being captured or drained are dropped
// and recorded in a sticky overrun flag; the one exception is a new frame that
// starts on the very cycle the last sample of the current frame is accepted.
module fft_out_serializer #(
    parameter int NBITS_out = 10,
    parameter int N         = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_out_serializer_if.slave  bus
);

    localparam int W      = 2 * NBITS_out;
    localparam int GROUPS = N / 4;
    localparam int IW     = $clog2(N);
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN
    } stateType;

    stateType        state;
    logic [GW-1:0]   groupCount;
    logic [IW-1:0]   readPtr;
    logic [W-1:0]    doutReg;
    logic            doutValid;
    logic            doutLast;
    logic            overrunFlag;

    logic [W-1:0]    mem [4][GROUPS];

    logic            transfer;
    logic            finalTransfer;
    logic            startAccepted;
    logic            droppedFrame;
    logic            writeEn;
    logic [GW-1:0]   writeAddr;
    logic            lastGroupWrite;
    logic [IW-1:0]   nextPtr;
    logic [W-1:0]    nextWord;
    logic [W-1:0]    firstWord;

    // Decode handshake events, frame acceptance and the storage access for this cycle
    always_comb begin
        transfer       = doutValid && bus.dout_ready;
        finalTransfer  = (state == DRAIN) && transfer && (readPtr == IW'(N - 1));
        startAccepted  = bus.in_start && ((state == IDLE) || finalTransfer);
        droppedFrame   = bus.in_start && !startAccepted;
        writeEn        = startAccepted || (state == CAPTURE);
        writeAddr      = (state == CAPTURE) ? groupCount : '0;
        lastGroupWrite = writeEn && (writeAddr == GW'(GROUPS - 1));
        nextPtr        = readPtr + IW'(1);
        nextWord       = mem[nextPtr[1:0]][GW'(nextPtr >> 2)];
        firstWord      = (GROUPS == 1) ? bus.fftOut0_up : mem[0][0];
    end

    // Lane k=4c+j of group c lands in bank j at address c; lanes are ignored outside capture
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[0][writeAddr] <= bus.fftOut0_up;
            mem[1][writeAddr] <= bus.fftOut0_down;
            mem[2][writeAddr] <= bus.fftOut1_up;
            mem[3][writeAddr] <= bus.fftOut1_down;
        end
    end

    // Capture/drain sequencer with registered stream outputs and sticky overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            groupCount  <= '0;
            readPtr     <= '0;
            doutReg     <= '0;
            doutValid   <= 1'b0;
            doutLast    <= 1'b0;
            overrunFlag <= 1'b0;
        end else begin
            overrunFlag <= droppedFrame || (overrunFlag && !bus.overrun_clr);

            case (state)
                IDLE: begin
                    if (startAccepted) begin
                        if (lastGroupWrite) begin
                            state     <= DRAIN;
                            readPtr   <= '0;
                            doutReg   <= firstWord;
                            doutValid <= 1'b1;
                            doutLast  <= 1'b0;
                        end else begin
                            state      <= CAPTURE;
                            groupCount <= GW'(1);
                        end
                    end
                end

                CAPTURE: begin
                    if (lastGroupWrite) begin
                        state      <= DRAIN;
                        groupCount <= '0;
                        readPtr    <= '0;
                        doutReg    <= firstWord;
                        doutValid  <= 1'b1;
                        doutLast   <= 1'b0;
                    end else begin
                        groupCount <= groupCount + GW'(1);
                    end
                end

                DRAIN: begin
                    if (transfer) begin
                        if (finalTransfer) begin
                            doutValid <= 1'b0;
                            doutLast  <= 1'b0;
                            if (startAccepted) begin
                                if (lastGroupWrite) begin
                                    state     <= DRAIN;
                                    readPtr   <= '0;
                                    doutReg   <= firstWord;
                                    doutValid <= 1'b1;
                                end else begin
                                    state      <= CAPTURE;
                                    groupCount <= GW'(1);
                                end
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            readPtr  <= nextPtr;
                            doutReg  <= nextWord;
                            doutLast <= (nextPtr == IW'(N - 1));
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    doutValid <= 1'b0;
                    doutLast  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dout       = doutReg;
    assign bus.dout_index = readPtr;
    assign bus.dout_valid = doutValid;
    assign bus.dout_last  = doutLast;
    assign bus.busy       = (state != IDLE);
    assign bus.overrun    = overrunFlag;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer: a table of frame scenarios,
// hand-written reset and clear sequences, and a randomized stress run, all
// checked against a frame-level queue model of the serializer.
module tb_fft_out_serializer;

    localparam int NB     = 10;
    localparam int NPTS   = 128;
    localparam int GROUPS = NPTS / 4;
    localparam int W      = 2 * NB;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fft_out_serializer_if #(.NBITS_out(NB), .N(NPTS)) bus ();

    fft_out_serializer #(.NBITS_out(NB), .N(NPTS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    base;
        int    readyMode;
        int    extraKind;
        int    extraAt;
        int    extraBase;
        int    expXfers;
        bit    expOverrun;
    } scenT;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] expQ [$];
    logic [W-1:0] capQ [$];
    int  capGroups = 0;
    bit  ovModel   = 1'b0;
    int  genGroup  = -1;
    int  genBase   = 0;
    int  xferSeen  = 0;

    scenT scen [6];

    function automatic logic [W-1:0] mkWord(input int base, input int k);
        logic [NB-1:0] re;
        re = NB'(base + k);
        return {re, {NB{1'b0}}};
    endfunction

    function automatic bit readyFor(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput();
        bit expValid;
        expValid = (expQ.size() > 0);
        compare("busy", 32'(bus.busy), 32'((capGroups > 0) || (expQ.size() > 0)));
        compare("overrun", 32'(bus.overrun), 32'(ovModel));
        compare("dout_valid", 32'(bus.dout_valid), 32'(expValid));
        if (expValid && bus.dout_valid) begin
            compare("dout", 32'(bus.dout), 32'(expQ[0]));
            compare("dout_index", 32'(bus.dout_index), 32'(NPTS - expQ.size()));
            compare("dout_last", 32'(bus.dout_last), 32'(expQ.size() == 1));
        end
    endtask

    task automatic applyStimulus(input bit start, input bit restart, input int base,
                                 input bit ready, input bit clr);
        logic [W-1:0] lanes [4];
        int  sz;
        bit  xfer;
        bit  lastX;
        bit  setOv;
        if (start && restart) begin
            genBase  = base;
            genGroup = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (genGroup >= 0 && genGroup < GROUPS)
                lanes[i] = mkWord(genBase, 4 * genGroup + i);
            else
                lanes[i] = W'($urandom);
        end
        if (genGroup >= 0) begin
            genGroup++;
            if (genGroup >= GROUPS) genGroup = -1;
        end
        bus.in_start     = start;
        bus.fftOut0_up   = lanes[0];
        bus.fftOut0_down = lanes[1];
        bus.fftOut1_up   = lanes[2];
        bus.fftOut1_down = lanes[3];
        bus.dout_ready   = ready;
        bus.overrun_clr  = clr;
        if (bus.dout_valid && ready) xferSeen++;

        sz    = expQ.size();
        xfer  = (sz > 0) && ready;
        lastX = xfer && (sz == 1);
        setOv = 1'b0;
        if (capGroups > 0) begin
            for (int i = 0; i < 4; i++) capQ.push_back(lanes[i]);
            if (start) setOv = 1'b1;
            capGroups++;
        end else if (start) begin
            if (sz == 0 || lastX) begin
                capQ.delete();
                for (int i = 0; i < 4; i++) capQ.push_back(lanes[i]);
                capGroups = 1;
            end else begin
                setOv = 1'b1;
            end
        end
        if (xfer) void'(expQ.pop_front());
        if (capGroups == GROUPS) begin
            expQ = capQ;
            capQ.delete();
            capGroups = 0;
        end
        ovModel = setOv || (ovModel && !clr);

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic runScenario(input scenT s);
        int cyc;
        int firstValid;
        bit extraDone;
        bit rdy;
        bit st;
        bit rs;
        int b;
        cyc        = 0;
        firstValid = -1;
        extraDone  = 1'b0;
        xferSeen   = 0;
        checkOutput();
        applyStimulus(1'b1, 1'b1, s.base, 1'b1, 1'b0);
        cyc = 1;
        while (cyc < 3000) begin
            checkOutput();
            if (firstValid < 0 && bus.dout_valid) firstValid = cyc;
            if (!((capGroups > 0) || (expQ.size() > 0))) break;
            rdy = readyFor(s.readyMode, cyc);
            st  = 1'b0;
            rs  = 1'b0;
            b   = 0;
            case (s.extraKind)
                1: if (!extraDone && expQ.size() > 0 && (NPTS - expQ.size()) == s.extraAt) begin
                       st = 1'b1; rs = 1'b1; b = s.extraBase; extraDone = 1'b1;
                   end
                2: if (!extraDone && expQ.size() == 1) begin
                       rdy = 1'b1; st = 1'b1; rs = 1'b1; b = s.extraBase; extraDone = 1'b1;
                   end
                3: if (!extraDone && genGroup == s.extraAt) begin
                       st = 1'b1; extraDone = 1'b1;
                   end
                default: ;
            endcase
            applyStimulus(st, rs, b, rdy, 1'b0);
            cyc++;
        end
        if (cyc >= 3000) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout: still busy after %0d cycles, required idle", s.name, cyc);
        end
        compare({s.name, " transfers"}, 32'(xferSeen), 32'(s.expXfers));
        compare({s.name, " overrun"}, 32'(bus.overrun), 32'(s.expOverrun));
        compare({s.name, " latency"}, 32'(firstValid), 32'(GROUPS));
        compare({s.name, " busy at end"}, 32'(bus.busy), 32'(0));
        if (s.expOverrun) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b1);
            compare({s.name, " overrun_clr"}, 32'(bus.overrun), 32'(0));
            checkOutput();
        end
        $display("[TB] scenario %s done", s.name);
    endtask

    task automatic checkResetOutputs(input string tag);
        compare({tag, " dout_valid"}, 32'(bus.dout_valid), 32'(0));
        compare({tag, " dout"}, 32'(bus.dout), 32'(0));
        compare({tag, " dout_index"}, 32'(bus.dout_index), 32'(0));
        compare({tag, " dout_last"}, 32'(bus.dout_last), 32'(0));
        compare({tag, " busy"}, 32'(bus.busy), 32'(0));
        compare({tag, " overrun"}, 32'(bus.overrun), 32'(0));
    endtask

    task automatic modelReset();
        expQ.delete();
        capQ.delete();
        capGroups = 0;
        ovModel   = 1'b0;
        genGroup  = -1;
    endtask

    // Main sequence: reset, scenario table, reset mid-drain, random stress
    initial begin
        int guard;
        scenT s;
        bit st;
        bit rs;
        bit clr;
        bit rdy;

        scen[0] = '{"basic",        0,  0, 0, 0,  0,    128, 1'b0};
        scen[1] = '{"backpressure", 0,  1, 0, 0,  0,    128, 1'b0};
        scen[2] = '{"overrun",      0,  0, 1, 40, 1000, 128, 1'b1};
        scen[3] = '{"backtoback",   0,  0, 2, 0,  500,  256, 1'b0};
        scen[4] = '{"midcapture",   0,  0, 3, 10, 0,    128, 1'b1};
        scen[5] = '{"randomready",  77, 2, 0, 0,  0,    128, 1'b0};

        bus.in_start     = 1'b0;
        bus.fftOut0_up   = '0;
        bus.fftOut0_down = '0;
        bus.fftOut1_up   = '0;
        bus.fftOut1_down = '0;
        bus.dout_ready   = 1'b0;
        bus.overrun_clr  = 1'b0;

        #3;
        checkResetOutputs("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) runScenario(scen[i]);

        checkOutput();
        applyStimulus(1'b1, 1'b1, 0, 1'b1, 1'b0);
        guard = 0;
        while (!(expQ.size() > 0 && (NPTS - expQ.size()) == 60) && guard < 200) begin
            checkOutput();
            applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("[TB] FAIL reset setup timeout: drain index 60 not reached, required within 200 cycles");
        end
        #2;
        rst = 1'b0;
        #1;
        checkResetOutputs("async reset");
        modelReset();
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
        checkResetOutputs("held reset");
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput();
            applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
        end
        s = '{"postreset", 300, 0, 0, 0, 0, 128, 1'b0};
        runScenario(s);

        for (int i = 0; i < 2500; i++) begin
            checkOutput();
            st  = ($urandom_range(0, 39) == 0);
            rs  = st && ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 29) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            applyStimulus(st, rs, int'($urandom_range(0, 1023)), rdy, clr);
        end
        guard = 0;
        while (((capGroups > 0) || (expQ.size() > 0)) && guard < 400) begin
            checkOutput();
            applyStimulus(1'b0, 1'b0, 0, 1'b1, 1'b0);
            guard++;
        end
        if (guard >= 400) begin
            checks++;
            failures++;
            $display("[TB] FAIL stress drain timeout: model still busy, required idle within 400 cycles");
        end
        checkOutput();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
- Sink for the 4-lane parallel output of the N-point FFT core (topfft): captures one frame of 4 complex samples per clock.
- Drains the frame as a single natural-order complex stream with valid/ready handshake, for the downstream DMA/UART path.
- Capture-then-drain: a frame arriving while the block is busy is dropped and flagged.

Parameters:
- NBITS_out, 10, bits per real/imag component; sample word = 2*NBITS_out (re in upper half, im in lower half; opaque to this block).
- N, 128, FFT points per frame; must be a multiple of 4, and N/4 must be a power of 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_start  in  1  high on the cycle the first group (k=0..3) of a frame is on the lanes.
- fftOut0_up  in  2*NBITS_out  lane 0, sample k=4c+0.
- fftOut0_down  in  2*NBITS_out  lane 1, sample k=4c+1.
- fftOut1_up  in  2*NBITS_out  lane 2, sample k=4c+2.
- fftOut1_down  in  2*NBITS_out  lane 3, sample k=4c+3.
- dout  out  2*NBITS_out  serial sample.
- dout_index  out  clog2(N)  index k of dout.
- dout_valid  out  1  dout/dout_index/dout_last valid.
- dout_ready  in  1  downstream accepts.
- dout_last  out  1  high with k=N-1.
- busy  out  1  state != IDLE.
- overrun  out  1  sticky dropped-frame flag.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; group count=0; read pointer=0; dout=0, dout_index=0, dout_valid=0, dout_last=0, busy=0, overrun=0. Storage contents are don't-care.
- Reset asserted mid-operation aborts the frame. No output is produced until the next in_start.
- Storage: N words (4 banks of N/4). Group c writes lanes 0..3 to k=4c..4c+3.
- IDLE:
  - in_start=1: write group 0, set count=1, go to CAPTURE.
  - Otherwise hold.
- CAPTURE:
  - Write group `count` every cycle unconditionally; lanes have no stall.
  - in_start=1 in this state is ignored for data and sets overrun.
  - After writing group N/4-1, go to DRAIN with read pointer=0.
  - The capture takes exactly N/4 cycles.
- DRAIN:
  - dout_valid=1, dout=mem[rp], dout_index=rp, dout_last=(rp==N-1).
  - Outputs are registered and stable while dout_valid=1 and dout_ready=0.
  - A transfer occurs when dout_valid and dout_ready are both high; it advances rp.
  - First dout_valid appears the cycle after the final group is written.
  - With dout_ready held at 1, the drain takes N cycles.
  - Transfer of k=N-1: dout_valid drops next cycle, state returns to IDLE.
- in_start during DRAIN:
  - Frame dropped, overrun set, drain continues undisturbed.
  - Exception: in_start on the same cycle as the k=N-1 transfer is accepted. Group 0 is written, state goes directly to CAPTURE with count=1, no overrun.
- overrun:
  - Set by any dropped frame or mid-CAPTURE in_start.
  - Cleared by overrun_clr.
  - If set and clear occur in the same cycle, set wins.
- busy = (state != IDLE).
- Lane inputs are sampled only in IDLE (with in_start) and in CAPTURE; X/Z on lanes at other times must not propagate.

Test Plan:
- Basic frame, N=128, dout_ready=1:
  - Stimulus: in_start pulse, lane value re=k, im=0 for 32 cycles.
  - Expected: dout k=0..127 in order on consecutive cycles; first valid 32 cycles after the in_start edge; dout_last only at index 127; busy low after.
- Backpressure, same frame, dout_ready toggling 1,0,0,1 repeating:
  - Expected: 128 transfers, no sample skipped or repeated; dout stable while ready=0.
- Overrun:
  - Stimulus: second in_start at drain index 40 (data 1000+k).
  - Expected: first frame output intact, overrun=1, no second frame output. overrun_clr then sets overrun=0.
- Back-to-back:
  - Stimulus: second in_start on the cycle of the index-127 transfer (data 500+k).
  - Expected: second frame captured and drained fully (500..627), overrun=0.
- Reset mid-drain:
  - Stimulus: rst=0 at drain index 60.
  - Expected: outputs 0 immediately (asynchronous); after release, idle until next in_start; a new frame drains correctly from k=0.
- Mid-capture in_start:
  - Stimulus: in_start re-asserted at group 10.
  - Expected: overrun=1; captured frame unchanged (values re=k).
